// File: rtl/seq_req_master.sv
// seq_req_master: issues a length request to a counted-sequence source, then
// consumes and checks the returned stream 0..len, reporting sum, beat count
// and error flags as a result record.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_len    command input (requested final value)
//   req_rdy/req_ack/req_len        request handshake toward the source
//   rsp_rdy/rsp_ack/rsp_data       response beats from the source
//   hold                           backpressure injection, forces rsp_ack low
//   res_valid/res_ready            result handshake
//   res_sum/res_beats/res_err      result record (err[0] mismatch, err[1] timeout)
module seq_req_master #(
  parameter int unsigned W       = 11,
  parameter int unsigned SW      = 2 * W,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [W-1:0]    cmd_len,
  output logic            req_rdy,
  input  logic            req_ack,
  output logic [W-1:0]    req_len,
  input  logic            rsp_rdy,
  output logic            rsp_ack,
  input  logic [W-1:0]    rsp_data,
  input  logic            hold,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [SW-1:0]   res_sum,
  output logic [W:0]      res_beats,
  output logic [1:0]      res_err
);

  localparam int unsigned BW = W + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RECV = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    len_q, len_d;
  logic [W-1:0]    expect_q, expect_d;
  logic [SW-1:0]   sum_q, sum_d;
  logic [BW-1:0]   beats_q, beats_d;
  logic [1:0]      err_q, err_d;
  logic [TW-1:0]   timer_q, timer_d;

  logic            beat;
  logic            last_beat;
  logic [BW-1:0]   beats_inc;
  logic [TW-1:0]   timer_inc;

  // A beat is consumed only in RECV while not held back.
  assign beat      = (state_q == S_RECV) && rsp_rdy && !hold;
  assign beats_inc = beats_q + BW'(1);
  assign timer_inc = timer_q + TW'(1);
  // Stop on the final value, or once len+1 beats have arrived even if the
  // data was wrong, so expect never runs past len.
  assign last_beat = (rsp_data == len_q) || (beats_inc == (BW'(len_q) + BW'(1)));

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      expect_q <= '0;
      sum_q    <= '0;
      beats_q  <= '0;
      err_q    <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      expect_q <= expect_d;
      sum_q    <= sum_d;
      beats_q  <= beats_d;
      err_q    <= err_d;
      timer_q  <= timer_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    expect_d = expect_q;
    sum_d    = sum_q;
    beats_d  = beats_q;
    err_d    = err_q;
    timer_d  = timer_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          len_d   = cmd_len;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (req_ack) begin
          expect_d = '0;
          sum_d    = '0;
          beats_d  = '0;
          err_d    = '0;
          timer_d  = '0;
          state_d  = S_RECV;
        end
      end
      S_RECV: begin
        if (beat) begin
          if (rsp_data != expect_q) err_d[0] = 1'b1;
          sum_d    = sum_q + SW'(rsp_data);
          beats_d  = beats_inc;
          expect_d = expect_q + W'(1);
          timer_d  = '0;
          if (last_beat) state_d = S_DONE;
        end else begin
          timer_d = timer_inc;
          // Held cycles count as idle too; the timeout is wall-clock.
          if (timer_inc == TW'(TIMEOUT)) begin
            err_d[1] = 1'b1;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and payload outputs decoded from state.
  always_comb begin
    cmd_ready = 1'b0;
    req_rdy   = 1'b0;
    req_len   = '0;
    rsp_ack   = 1'b0;
    res_valid = 1'b0;
    res_sum   = '0;
    res_beats = '0;
    res_err   = '0;
    unique case (state_q)
      S_IDLE: cmd_ready = 1'b1;
      S_REQ: begin
        req_rdy = 1'b1;
        req_len = len_q;
      end
      S_RECV: rsp_ack = !hold;
      S_DONE: begin
        res_valid = 1'b1;
        res_sum   = sum_q;
        res_beats = beats_q;
        res_err   = err_q;
      end
      default: cmd_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_seq_req_master.sv
// Directed bench for seq_req_master: drives commands, plays a scripted
// sequence source, and checks handshakes and result records against
// hand-computed values.
module tb_seq_req_master;

  localparam int unsigned W  = 11;
  localparam int unsigned SW = 2 * W;
  localparam int unsigned TO = 8;

  logic            clk;
  logic            rst;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [W-1:0]    cmd_len;
  logic            req_rdy;
  logic            req_ack;
  logic [W-1:0]    req_len;
  logic            rsp_rdy;
  logic            rsp_ack;
  logic [W-1:0]    rsp_data;
  logic            hold;
  logic            res_valid;
  logic            res_ready;
  logic [SW-1:0]   res_sum;
  logic [W:0]      res_beats;
  logic [1:0]      res_err;

  int total = 0;
  int bad   = 0;
  int src_vals[$];

  seq_req_master #(.W(W), .SW(SW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_len   (cmd_len),
    .req_rdy   (req_rdy),
    .req_ack   (req_ack),
    .req_len   (req_len),
    .rsp_rdy   (rsp_rdy),
    .rsp_ack   (rsp_ack),
    .rsp_data  (rsp_data),
    .hold      (hold),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_beats (res_beats),
    .res_err   (res_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a command and complete the request handshake after ack_delay cycles.
  task automatic send_cmd(input int len, input int ack_delay, output int req_cycles);
    chk("cmd_ready_idle", 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_len   = 11'(len);
    step();
    cmd_valid = 1'b0;
    req_cycles = 0;
    chk("cmd_ready_busy", 32'(cmd_ready), 0);
    chk("req_rdy_rise", 32'(req_rdy), 1);
    chk("req_len", 32'(req_len), 32'(len));
    for (int d = 0; d < ack_delay; d++) begin
      if (req_rdy) req_cycles++;
      step();
      chk("req_rdy_stable", 32'(req_rdy), 1);
      chk("req_len_stable", 32'(req_len), 32'(len));
    end
    if (req_rdy) req_cycles++;
    req_ack = 1'b1;
    step();
    req_ack = 1'b0;
    chk("req_rdy_fall", 32'(req_rdy), 0);
    chk("req_len_zero", 32'(req_len), 0);
  endtask

  // Play src_vals as the source. hold_mode 1 holds on even cycles.
  // lat = edges from the last accepted beat until res_valid is seen;
  // span = edges from first to last accepted beat, inclusive.
  task automatic stream(input int hold_mode, output int nbeats, output int span, output int lat);
    int  idx;
    int  since;
    int  first_c;
    int  last_c;
    bit  acc;
    bit  done;
    idx = 0; since = 0; first_c = -1; last_c = -1; done = 0; lat = -1;
    for (int c = 0; c < 5000; c++) begin
      hold     = (hold_mode == 1) && (c % 2 == 0);
      rsp_rdy  = (idx < src_vals.size());
      rsp_data = rsp_rdy ? 11'(src_vals[idx]) : '0;
      #1;
      if (hold) chk("ack_low_on_hold", 32'(rsp_ack), 0);
      acc = rsp_rdy && rsp_ack;
      step();
      if (acc) begin
        idx++;
        since = 0;
        if (first_c < 0) first_c = c;
        last_c = c;
      end else begin
        since++;
      end
      if (res_valid) begin
        lat  = since;
        done = 1;
        break;
      end
    end
    if (!done) chk("res_valid_budget", 0, 1);
    rsp_rdy  = 1'b0;
    rsp_data = '0;
    hold     = 1'b0;
    nbeats = idx;
    span   = (first_c < 0) ? 0 : (last_c - first_c + 1);
  endtask

  // Check the result record, hold it for `stall` cycles, then consume it.
  task automatic check_result(input int sum, input int beats, input int err, input int stall);
    chk("res_valid", 32'(res_valid), 1);
    chk("res_sum", 32'(res_sum), 32'(sum));
    chk("res_beats", 32'(res_beats), 32'(beats));
    chk("res_err", 32'(res_err), 32'(err));
    res_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      step();
      chk("res_valid_stall", 32'(res_valid), 1);
      chk("res_sum_stall", 32'(res_sum), 32'(sum));
      chk("res_beats_stall", 32'(res_beats), 32'(beats));
      chk("cmd_ready_stall", 32'(cmd_ready), 0);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("res_valid_fall", 32'(res_valid), 0);
    chk("cmd_ready_back", 32'(cmd_ready), 1);
    chk("res_sum_cleared", 32'(res_sum), 0);
  endtask

  initial begin
    int rq;
    int nb;
    int sp;
    int lt;
    rst = 1'b0;
    cmd_valid = 1'b0; cmd_len = '0; req_ack = 1'b0;
    rsp_rdy = 1'b1; rsp_data = '0; hold = 1'b0; res_ready = 1'b0;
    step();
    step();
    // Reset values, with a stray beat offered outside RECV.
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_req_rdy", 32'(req_rdy), 0);
    chk("rst_rsp_ack", 32'(rsp_ack), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_req_len", 32'(req_len), 0);
    chk("rst_res_sum", 32'(res_sum), 0);
    chk("rst_res_beats", 32'(res_beats), 0);
    chk("rst_res_err", 32'(res_err), 0);
    rst = 1'b1;
    step();
    chk("idle_rsp_ack", 32'(rsp_ack), 0);
    rsp_rdy = 1'b0;

    // len 0: single beat, request accepted immediately.
    send_cmd(0, 0, rq);
    chk("t1_req_cycles", 32'(rq), 1);
    src_vals = '{0};
    stream(0, nb, sp, lt);
    chk("t1_beats_seen", 32'(nb), 1);
    chk("t1_latency", 32'(lt), 0);
    check_result(0, 1, 0, 0);

    // len 5, back-to-back stream; request ack delayed 2 cycles.
    send_cmd(5, 2, rq);
    chk("t2_req_cycles", 32'(rq), 3);
    src_vals = '{0, 1, 2, 3, 4, 5};
    stream(0, nb, sp, lt);
    chk("t2_span", 32'(sp), 6);
    chk("t2_latency", 32'(lt), 0);
    check_result(15, 6, 0, 0);

    // len 3 with hold toggling and a 4-cycle result stall.
    send_cmd(3, 0, rq);
    src_vals = '{0, 1, 2, 3};
    stream(1, nb, sp, lt);
    chk("t3_beats_seen", 32'(nb), 4);
    chk("t3_span", 32'(sp), 7);
    check_result(6, 4, 0, 4);

    // len 4, source skips 2: mismatch flagged, ends on value 4.
    send_cmd(4, 0, rq);
    src_vals = '{0, 1, 3, 4};
    stream(0, nb, sp, lt);
    chk("t4_beats_seen", 32'(nb), 4);
    check_result(8, 4, 1, 0);

    // len 2, source stalls after beat 0: timeout after 8 idle cycles.
    send_cmd(2, 0, rq);
    src_vals = '{0};
    stream(0, nb, sp, lt);
    chk("t5_timeout_lat", 32'(lt), 8);
    check_result(0, 1, 2, 0);

    // Full-range stream.
    send_cmd(2047, 0, rq);
    src_vals.delete();
    for (int v = 0; v <= 2047; v++) src_vals.push_back(v);
    stream(0, nb, sp, lt);
    chk("t6_span", 32'(sp), 2048);
    check_result(2096128, 2048, 0, 0);

    // Reset asserted mid-RECV clears everything immediately.
    send_cmd(10, 0, rq);
    rsp_rdy = 1'b1; rsp_data = 11'(0);
    step();
    rsp_data = 11'(1);
    step();
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_rsp_ack", 32'(rsp_ack), 0);
    chk("mid_rst_req_rdy", 32'(req_rdy), 0);
    chk("mid_rst_res_valid", 32'(res_valid), 0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 1);
    rsp_rdy = 1'b0; rsp_data = '0;
    step();
    rst = 1'b1;
    step();

    // Normal command after reset.
    send_cmd(1, 0, rq);
    src_vals = '{0, 1};
    stream(0, nb, sp, lt);
    chk("t7_beats_seen", 32'(nb), 2);
    check_result(1, 2, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
